// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word loads and stores into word-wide data memory accesses
module load_store_unit #(
   parameter int AWIDTH     = 32,
   parameter int MEM_RD_LAT = 1
) (
   input  logic              ls_clk,
   input  logic              ls_rst,
   input  logic              ls_req,
   output logic              ls_ready,
   input  logic              ls_we,
   input  logic [2:0]        ls_funct3,
   input  logic [AWIDTH-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic [31:0]       ls_rdata,
   output logic              ls_done,
   output logic              ls_err,
   output logic              mem_re,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [2:0] {IDLE, ERR, RD, CAP, MRG, WR, RESP} state_t;
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d, f3_q, f3_d;
   logic              we_q, we_d;
   logic [1:0]        off_q, off_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
   logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic              accept, illegal, misaligned;
   logic [4:0]        sh;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       ld_val, merged, bmask;
   assign accept     = state_q == IDLE && ls_req;
   assign illegal    = ls_we ? (ls_funct3[2] | &ls_funct3[1:0]) : (&ls_funct3[1:0] | &ls_funct3[2:1]);
   assign misaligned = ls_funct3[0] ? ls_addr[0] : ls_funct3[1] ? |ls_addr[1:0] : 1'b0;
   assign sh         = {off_q, 3'b000};
   assign lane_b     = 8'(mem_rdata >> sh);
   assign lane_h     = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   assign ld_val     = f3_q[1] ? mem_rdata :
                       f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} :
                                 {{24{~f3_q[2] & lane_b[7]}}, lane_b};
   assign bmask      = 32'hFF << sh;
   assign merged     = f3_q[0] ? (off_q[1] ? {wdata_q, mem_rdata[15:0]} : {mem_rdata[31:16], wdata_q}) :
                                 ((mem_rdata & ~bmask) | ({24'd0, wdata_q[7:0]} << sh));
   assign ls_ready   = state_q == IDLE;
   assign ls_done    = state_q == ERR || state_q == RESP;
   assign ls_err     = state_q == ERR;
   assign mem_re     = state_q == RD;
   assign mem_we     = state_q == WR;
   assign ls_rdata   = rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   // next state: decode on accept, hold RD for the memory read latency, then capture or merge
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ls_req) state_d = (illegal | misaligned) ? ERR : (ls_we && ls_funct3[1]) ? WR : RD;
         RD:      if (cnt_q == 3'(MEM_RD_LAT - 1)) state_d = we_q ? MRG : CAP;
         CAP:     state_d = RESP;
         MRG:     state_d = WR;
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end
   // request capture, load extension and sub-word store merge
   always_comb begin
      cnt_d       = state_q == RD ? cnt_q + 3'd1 : 3'd0;
      f3_d        = accept ? ls_funct3 : f3_q;
      we_d        = accept ? ls_we : we_q;
      off_d       = accept ? ls_addr[1:0] : off_q;
      wdata_d     = accept ? ls_wdata[15:0] : wdata_q;
      mem_addr_d  = accept ? ls_addr >> 2 : mem_addr_q;
      mem_wdata_d = accept ? ls_wdata : state_q == MRG ? merged : mem_wdata_q;
      rdata_d     = state_q == CAP ? ld_val : 32'd0;
   end
   // state and datapath registers
   always_ff @(posedge ls_clk) begin
      if (ls_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         f3_q        <= '0;
         we_q        <= 1'b0;
         off_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         f3_q        <= f3_d;
         we_q        <= we_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of two load_store_unit instances (read latency 1 and 3)
module tb_load_store_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [1:0]       rst, req, we, ready, done, err, mem_re, mem_we;
   logic [1:0][2:0]  f3;
   logic [1:0][31:0] addr, wdata, rdata, maddr, mwdata, mrdata;
   logic [31:0]      mem [2][16];
   logic [31:0]      dl [2][4];
   logic [31:0]      we_addr [2], we_data [2];
   int cyc = 0, checks = 0, failures = 0, t_acc = 0;
   int re_cnt [2] = '{0, 0};
   int we_cnt [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   int acc_cnt [2] = '{0, 0};
   int both_cnt [2] = '{0, 0};
   int we_cyc [2] = '{0, 0};
   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : u_g
         load_store_unit #(.AWIDTH(32), .MEM_RD_LAT(g == 0 ? 1 : 3)) dut (
            .ls_clk(clk), .ls_rst(rst[g]), .ls_req(req[g]), .ls_ready(ready[g]),
            .ls_we(we[g]), .ls_funct3(f3[g]), .ls_addr(addr[g]), .ls_wdata(wdata[g]),
            .ls_rdata(rdata[g]), .ls_done(done[g]), .ls_err(err[g]),
            .mem_re(mem_re[g]), .mem_we(mem_we[g]), .mem_addr(maddr[g]),
            .mem_wdata(mwdata[g]), .mem_rdata(mrdata[g]));
      end
   endgenerate
   // word memory with an L-stage read pipeline, plus event monitors
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int u = 0; u < 2; u++) begin
         if (mem_we[u]) begin
            mem[u][maddr[u][3:0]] <= mwdata[u];
            we_cnt[u]  <= we_cnt[u] + 1;
            we_cyc[u]  <= cyc;
            we_addr[u] <= maddr[u];
            we_data[u] <= mwdata[u];
         end
         dl[u][0] <= mem_re[u] ? mem[u][maddr[u][3:0]] : 32'hDEADDEAD;
         for (int k = 1; k < 4; k++) dl[u][k] <= dl[u][k-1];
         if (mem_re[u]) re_cnt[u] <= re_cnt[u] + 1;
         if (done[u]) done_cnt[u] <= done_cnt[u] + 1;
         if (req[u] && ready[u]) acc_cnt[u] <= acc_cnt[u] + 1;
         if (mem_re[u] && mem_we[u]) both_cnt[u] <= both_cnt[u] + 1;
      end
   end
   always_comb for (int u = 0; u < 2; u++) mrdata[u] = dl[u][u == 0 ? 0 : 2];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic op(input int u, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     input int lat, input logic [31:0] exp_rd, input logic exp_err, input int n_re, input int n_we,
                     input logic hold, input string tag);
      int r0, w0, k;
      logic got;
      @(negedge clk);
      k = 0;
      while (!ready[u] && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_ready"}, 32'(ready[u]), 32'd1);
      we[u] = w; f3[u] = f; addr[u] = a; wdata[u] = d; req[u] = 1'b1;
      t_acc = cyc; r0 = re_cnt[u]; w0 = we_cnt[u];
      got = 1'b0;
      for (k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (!hold) req[u] = 1'b0;
         got = done[u];
      end
      chk({tag, "_lat"}, 32'(cyc - t_acc), 32'(lat));
      chk({tag, "_rdata"}, rdata[u], exp_rd);
      chk({tag, "_err"}, 32'(err[u]), 32'(exp_err));
      chk({tag, "_re_cycles"}, 32'(re_cnt[u] - r0), 32'(n_re));
      chk({tag, "_we_cycles"}, 32'(we_cnt[u] - w0), 32'(n_we));
   endtask
   initial begin
      int d0, w0, a0;
      rst = 2'b11; req = '0; we = '0; f3 = '0; addr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      rst = 2'b00;
      for (int u = 0; u < 2; u++) begin
         chk("rst_ready", 32'(ready[u]), 32'd1);
         chk("rst_done", 32'(done[u]), 32'd0);
         chk("rst_err", 32'(err[u]), 32'd0);
         chk("rst_re_we", 32'({mem_re[u], mem_we[u]}), 32'd0);
         chk("rst_rdata", rdata[u], 32'd0);
         chk("rst_maddr", maddr[u], 32'd0);
         chk("rst_mwdata", mwdata[u], 32'd0);
      end
      op(0, 1'b1, 3'b010, 32'h10, 32'h876543A1, 2, 32'h0, 1'b0, 0, 1, 1'b0, "preload_sw");
      op(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h876543A1, 1'b0, 1, 0, 1'b0, "lw");
      chk("lw_maddr", maddr[0], 32'd4);
      op(0, 1'b0, 3'b000, 32'h10, 32'h0, 3, 32'hFFFFFFA1, 1'b0, 1, 0, 1'b0, "lb");
      op(0, 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h00000087, 1'b0, 1, 0, 1'b0, "lbu");
      op(0, 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF8765, 1'b0, 1, 0, 1'b0, "lh");
      op(0, 1'b0, 3'b101, 32'h10, 32'h0, 3, 32'h000043A1, 1'b0, 1, 0, 1'b0, "lhu");
      op(0, 1'b1, 3'b000, 32'h11, 32'h1234565A, 4, 32'h0, 1'b0, 1, 1, 1'b0, "sb");
      chk("sb_wdata", we_data[0], 32'h87655AA1);
      chk("sb_waddr", we_addr[0], 32'd4);
      chk("sb_we_cycle", 32'(we_cyc[0] - t_acc), 32'd3);
      op(0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 4, 32'h0, 1'b0, 1, 1, 1'b0, "sh");
      chk("sh_wdata", we_data[0], 32'hBEEF5AA1);
      op(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hBEEF5AA1, 1'b0, 1, 0, 1'b0, "lw_after_st");
      op(0, 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1, 1'b0, "sw");
      chk("sw_waddr", we_addr[0], 32'd5);
      chk("sw_wdata", we_data[0], 32'hDEADBEEF);
      chk("sw_we_cycle", 32'(we_cyc[0] - t_acc), 32'd1);
      op(0, 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1'b0, "err_lw_mis");
      op(0, 1'b1, 3'b001, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1'b0, "err_sh_mis");
      op(0, 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1'b0, "err_f3_011");
      op(0, 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1'b0, "err_st_f3_100");
      @(negedge clk);
      we[0] = 1'b1; f3[0] = 3'b000; addr[0] = 32'h11; wdata[0] = 32'hFFFFFF00; req[0] = 1'b1;
      d0 = done_cnt[0]; w0 = we_cnt[0];
      @(negedge clk);
      req[0] = 1'b0;
      chk("abort_in_rd", 32'(mem_re[0]), 32'd1);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("abort_ready", 32'(ready[0]), 32'd1);
      repeat (6) @(negedge clk);
      chk("abort_no_we", 32'(we_cnt[0] - w0), 32'd0);
      chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
      op(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hBEEF5AA1, 1'b0, 1, 0, 1'b0, "abort_readback");
      a0 = acc_cnt[1];
      for (int i = 0; i < 10; i++) begin
         op(1, 1'b1, 3'b010, 32'(4 * i), 32'(i), 2, 32'h0, 1'b0, 0, 1, 1'b1, "lat3_sw");
         op(1, 1'b0, 3'b010, 32'(4 * i), 32'h0, 5, 32'(i), 1'b0, 3, 0, 1'b1, "lat3_lw");
      end
      req[1] = 1'b0;
      chk("lat3_accepts", 32'(acc_cnt[1] - a0), 32'd20);
      for (int u = 0; u < 2; u++) chk("re_we_exclusive", 32'(both_cnt[u]), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
